// File: rtl/rpn_pkg.sv
// Shared opcode and multiplier-state definitions for the RPN stack calculator.
package rpn_pkg;

  localparam logic [2:0] OPC_NOP  = 3'd0;
  localparam logic [2:0] OPC_NEG  = 3'd1;
  localparam logic [2:0] OPC_ADD  = 3'd2;
  localparam logic [2:0] OPC_MUL  = 3'd3;
  localparam logic [2:0] OPC_SUB  = 3'd4;
  localparam logic [2:0] OPC_DUP  = 3'd5;
  localparam logic [2:0] OPC_SWAP = 3'd6;
  localparam logic [2:0] OPC_POP  = 3'd7;

  typedef enum logic [2:0] {
    OP_NOP  = OPC_NOP,
    OP_NEG  = OPC_NEG,
    OP_ADD  = OPC_ADD,
    OP_MUL  = OPC_MUL,
    OP_SUB  = OPC_SUB,
    OP_DUP  = OPC_DUP,
    OP_SWAP = OPC_SWAP,
    OP_POP  = OPC_POP
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mul_state_t;

endpackage

// File: rtl/rpn_stack_calc_if.sv
// Command/status bundle between the calculator front-end and the stack datapath.
interface rpn_stack_calc_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1000,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic             push;
  logic [WIDTH-1:0] d;
  logic [2:0]       op;
  logic [WIDTH-1:0] out;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             err;

  modport master (output push, d, op, input out, cnt, busy, err);
  modport slave  (input push, d, op, output out, cnt, busy, err);
endinterface

// File: rtl/rpn_seq_mul.sv
// Shift-add multiplier: one multiplier bit per edge, WIDTH iterations, low WIDTH bits kept.
module rpn_seq_mul
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             step,
  input  logic             nrst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int IW = $clog2(WIDTH + 1);

  mul_state_t       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [IW-1:0]    iter;

  // p is the accumulator after the current iteration, so it is final while done is high.
  always_comb begin
    p    = acc + (mplier[0] ? mcand : '0);
    busy = (state == RUN);
    done = (state == RUN) && (iter == IW'(1));
  end

  always_ff @(posedge step or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      iter   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            iter   <= IW'(WIDTH);
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= p;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          iter   <= iter - IW'(1);
          if (iter == IW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rpn_stack_calc.sv
// Reverse-Polish stack datapath: TOS register over a DEPTH-entry array, with
// overflow/underflow rejection and an iterative multiply that stalls commands.
module rpn_stack_calc
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1000,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             step,
  input  logic             nrst,
  rpn_stack_calc_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] tos, tos_n, nos;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             err_q, err_n;
  logic [AW-1:0]    top_idx, nos_idx, mem_wa;
  logic [WIDTH-1:0] mem_wd;
  logic             mem_we;
  logic             has1, has2, room;
  logic             mul_start, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_p;

  // Array holds everything below TOS; entry cnt-2 is NOS, entry cnt-1 is the next free slot.
  always_comb begin
    has1    = (cnt_q != '0);
    has2    = (cnt_q >= CNT_W'(2));
    room    = (cnt_q < CNT_W'(DEPTH));
    top_idx = AW'(cnt_q - CNT_W'(1));
    nos_idx = has2 ? AW'(cnt_q - CNT_W'(2)) : '0;
    nos     = mem[nos_idx];
  end

  rpn_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .step  (step),
    .nrst  (nrst),
    .start (mul_start),
    .a     (nos),
    .b     (tos),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_comb begin
    tos_n     = tos;
    cnt_n     = cnt_q;
    err_n     = 1'b0;
    mem_we    = 1'b0;
    mem_wa    = top_idx;
    mem_wd    = tos;
    mul_start = 1'b0;
    if (mul_done) begin
      tos_n = mul_p;
      cnt_n = cnt_q - CNT_W'(1);
    end else if (!mul_busy) begin
      if (bus.push) begin
        if (room) begin
          mem_we = has1;
          tos_n  = bus.d;
          cnt_n  = cnt_q + CNT_W'(1);
        end else begin
          err_n = 1'b1;
        end
      end else begin
        case (op_t'(bus.op))
          OP_NOP: ;
          OP_NEG: begin
            if (has1) tos_n = -tos;
            else      err_n = 1'b1;
          end
          OP_ADD: begin
            if (has2) begin
              tos_n = nos + tos;
              cnt_n = cnt_q - CNT_W'(1);
            end else err_n = 1'b1;
          end
          OP_SUB: begin
            if (has2) begin
              tos_n = nos - tos;
              cnt_n = cnt_q - CNT_W'(1);
            end else err_n = 1'b1;
          end
          OP_MUL: begin
            if (has2) mul_start = 1'b1;
            else      err_n = 1'b1;
          end
          OP_DUP: begin
            if (has1 && room) begin
              mem_we = 1'b1;
              cnt_n  = cnt_q + CNT_W'(1);
            end else err_n = 1'b1;
          end
          OP_SWAP: begin
            if (has2) begin
              tos_n  = nos;
              mem_we = 1'b1;
              mem_wa = nos_idx;
            end else err_n = 1'b1;
          end
          OP_POP: begin
            if (has1) begin
              tos_n = nos;
              cnt_n = cnt_q - CNT_W'(1);
            end else err_n = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge step) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge step or negedge nrst) begin
    if (!nrst) begin
      tos   <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      tos   <= tos_n;
      cnt_q <= cnt_n;
      err_q <= err_n;
    end
  end

  always_comb begin
    bus.out  = (cnt_q == '0) ? '0 : tos;
    bus.cnt  = cnt_q;
    bus.busy = mul_busy;
    bus.err  = err_q;
  end

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Directed-vector bench for rpn_stack_calc at WIDTH=16, DEPTH=4.
module tb_rpn_stack_calc;
  import rpn_pkg::*;

  logic step;
  logic nrst;
  int   compared;
  int   mismatched;

  typedef struct {
    logic        push;
    logic [15:0] d;
    logic [2:0]  op;
    logic [15:0] exp_out;
    logic [2:0]  exp_cnt;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  rpn_stack_calc_if #(.WIDTH(16), .DEPTH(4)) bus ();

  rpn_stack_calc #(.WIDTH(16), .DEPTH(4)) dut (
    .step (step),
    .nrst (nrst),
    .bus  (bus)
  );

  initial step = 1'b0;
  always #5 step = ~step;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic p, input logic [15:0] dv, input logic [2:0] o);
    @(negedge step);
    bus.push = p;
    bus.d    = dv;
    bus.op   = o;
    @(posedge step);
    #1;
    bus.push = 1'b0;
    bus.op   = OPC_NOP;
  endtask

  task automatic add(input logic p, input logic [15:0] dv, input logic [2:0] o,
                     input logic [15:0] eo, input logic [2:0] ec, input logic ee);
    vecs.push_back('{p, dv, o, eo, ec, ee});
  endtask

  // Pushes a and b, issues MUL, and checks the hold window, ignored pushes and the result edge.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [15:0] prod);
    apply(1'b1, a, OPC_NOP);
    apply(1'b1, b, OPC_NOP);
    apply(1'b0, 16'h0, OPC_MUL);
    check("mul.start.busy", 32'(bus.busy), 32'd1);
    check("mul.start.out", 32'(bus.out), 32'(b));
    check("mul.start.cnt", 32'(bus.cnt), 32'd2);
    for (int k = 1; k <= 16; k++) begin
      @(negedge step);
      bus.push = (k == 3) || (k == 16);
      bus.d    = 16'h5555;
      @(posedge step);
      #1;
      bus.push = 1'b0;
      if (k < 16) begin
        check($sformatf("mul.run%0d.busy", k), 32'(bus.busy), 32'd1);
        check($sformatf("mul.run%0d.out", k), 32'(bus.out), 32'(b));
        check($sformatf("mul.run%0d.cnt", k), 32'(bus.cnt), 32'd2);
        check($sformatf("mul.run%0d.err", k), 32'(bus.err), 32'd0);
      end
    end
    check("mul.done.busy", 32'(bus.busy), 32'd0);
    check("mul.done.out", 32'(bus.out), 32'(prod));
    check("mul.done.cnt", 32'(bus.cnt), 32'd1);
    check("mul.done.err", 32'(bus.err), 32'd0);
    apply(1'b0, 16'h0, OPC_NOP);
    check("mul.after.cnt", 32'(bus.cnt), 32'd1);
    check("mul.after.out", 32'(bus.out), 32'(prod));
    apply(1'b0, 16'h0, OPC_POP);
    check("mul.pop.cnt", 32'(bus.cnt), 32'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    nrst       = 1'b0;
    bus.push   = 1'b0;
    bus.d      = '0;
    bus.op     = OPC_NOP;

    add(1'b1, 16'd7,  OPC_NOP,  16'd7,    3'd1, 1'b0);
    add(1'b1, 16'd5,  OPC_NOP,  16'd5,    3'd2, 1'b0);
    add(1'b0, 16'd0,  OPC_SUB,  16'd2,    3'd1, 1'b0);
    add(1'b0, 16'd0,  OPC_NEG,  16'hFFFE, 3'd1, 1'b0);
    add(1'b1, 16'd3,  OPC_NOP,  16'd3,    3'd2, 1'b0);
    add(1'b0, 16'd0,  OPC_ADD,  16'd1,    3'd1, 1'b0);
    add(1'b0, 16'd0,  OPC_POP,  16'd0,    3'd0, 1'b0);
    add(1'b0, 16'd0,  OPC_NEG,  16'd0,    3'd0, 1'b1);
    add(1'b0, 16'd0,  OPC_ADD,  16'd0,    3'd0, 1'b1);
    add(1'b0, 16'd0,  OPC_POP,  16'd0,    3'd0, 1'b1);
    add(1'b0, 16'd0,  OPC_SWAP, 16'd0,    3'd0, 1'b1);
    add(1'b0, 16'd0,  OPC_MUL,  16'd0,    3'd0, 1'b1);
    add(1'b0, 16'd0,  OPC_DUP,  16'd0,    3'd0, 1'b1);
    add(1'b0, 16'd0,  OPC_NOP,  16'd0,    3'd0, 1'b0);
    add(1'b1, 16'd1,  OPC_NOP,  16'd1,    3'd1, 1'b0);
    add(1'b1, 16'd2,  OPC_NOP,  16'd2,    3'd2, 1'b0);
    add(1'b1, 16'd3,  OPC_NOP,  16'd3,    3'd3, 1'b0);
    add(1'b1, 16'd4,  OPC_NOP,  16'd4,    3'd4, 1'b0);
    add(1'b1, 16'd9,  OPC_NOP,  16'd4,    3'd4, 1'b1);
    add(1'b0, 16'd0,  OPC_DUP,  16'd4,    3'd4, 1'b1);
    add(1'b0, 16'd0,  OPC_POP,  16'd3,    3'd3, 1'b0);
    add(1'b0, 16'd0,  OPC_NOP,  16'd3,    3'd3, 1'b0);
    add(1'b0, 16'd0,  OPC_POP,  16'd2,    3'd2, 1'b0);
    add(1'b0, 16'd0,  OPC_POP,  16'd1,    3'd1, 1'b0);
    add(1'b0, 16'd0,  OPC_POP,  16'd0,    3'd0, 1'b0);
    add(1'b1, 16'd10, OPC_POP,  16'd10,   3'd1, 1'b0);
    add(1'b1, 16'd20, OPC_NOP,  16'd20,   3'd2, 1'b0);
    add(1'b0, 16'd0,  OPC_SWAP, 16'd10,   3'd2, 1'b0);
    add(1'b0, 16'd0,  OPC_POP,  16'd20,   3'd1, 1'b0);
    add(1'b0, 16'd0,  OPC_DUP,  16'd20,   3'd2, 1'b0);
    add(1'b0, 16'd0,  OPC_ADD,  16'd40,   3'd1, 1'b0);
    add(1'b0, 16'd0,  OPC_MUL,  16'd40,   3'd1, 1'b1);
    add(1'b0, 16'd0,  OPC_SWAP, 16'd40,   3'd1, 1'b1);
    add(1'b0, 16'd0,  OPC_NEG,  16'hFFD8, 3'd1, 1'b0);
    add(1'b0, 16'd0,  OPC_POP,  16'd0,    3'd0, 1'b0);

    repeat (2) @(posedge step);
    @(negedge step);
    nrst = 1'b1;
    #1;
    check("reset.out", 32'(bus.out), 32'd0);
    check("reset.cnt", 32'(bus.cnt), 32'd0);
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.err", 32'(bus.err), 32'd0);

    for (int i = 0; i < int'(vecs.size()); i++) begin
      apply(vecs[i].push, vecs[i].d, vecs[i].op);
      check($sformatf("v%0d.out", i), 32'(bus.out), 32'(vecs[i].exp_out));
      check($sformatf("v%0d.cnt", i), 32'(bus.cnt), 32'(vecs[i].exp_cnt));
      check($sformatf("v%0d.err", i), 32'(bus.err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d.busy", i), 32'(bus.busy), 32'd0);
    end

    run_mul(16'h0100, 16'h0101, 16'h0100);
    run_mul(16'hFFFE, 16'h0003, 16'hFFFA);
    run_mul(16'h1234, 16'h0000, 16'h0000);
    run_mul(16'hFFFF, 16'hFFFF, 16'h0001);

    // Asynchronous reset in the middle of a multiply.
    apply(1'b1, 16'd1, OPC_NOP);
    apply(1'b1, 16'd2, OPC_NOP);
    apply(1'b0, 16'd0, OPC_MUL);
    repeat (4) @(posedge step);
    #3;
    check("rstmul.busy_before", 32'(bus.busy), 32'd1);
    nrst = 1'b0;
    #1;
    check("rstmul.busy", 32'(bus.busy), 32'd0);
    check("rstmul.cnt", 32'(bus.cnt), 32'd0);
    check("rstmul.out", 32'(bus.out), 32'd0);
    check("rstmul.err", 32'(bus.err), 32'd0);
    @(negedge step);
    nrst = 1'b1;
    apply(1'b1, 16'd1, OPC_NOP);
    check("rstmul.push.out", 32'(bus.out), 32'd1);
    check("rstmul.push.cnt", 32'(bus.cnt), 32'd1);
    check("rstmul.push.busy", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
